// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the RV32I execute-side ALU dispatcher:
// ALU operation encoding, major opcodes and funct7 patterns.
package alu_dispatch_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 -> operation for the "base" (funct7 = 0) flavour of OP / OP-IMM.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_decode.sv
// Pure combinational RV32I decode for OP / OP-IMM / LUI / AUIPC into an
// ALU operation, operand pair, destination index and an illegal flag.
module rv32i_alu_decode
  import alu_dispatch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  alu_op_e     op;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};
  assign rd     = instr[11:7];

  // NOTE: every output of this block gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    op      = ALU_ADD;
    a       = '0;
    b       = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a = rs1_data;
        b = rs2_data;
        if (f7 == F7_BASE)                  op = base_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) op = ALU_SRA;
        else                                   illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        a  = rs1_data;
        b  = imm_i;
        op = base_op(f3);
        case (f3)
          3'b001: begin
            b = shamt;
            if (f7 != F7_BASE) illegal = 1'b1;
          end
          3'b101: begin
            b = shamt;
            if (f7 == F7_ALT)       op = ALU_SRA;
            else if (f7 != F7_BASE) illegal = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        b = imm_u;
      end
      OPC_AUIPC: begin
        a = pc;
        b = imm_u;
      end
      default: illegal = 1'b1;
    endcase

    // Illegal beats present a harmless ADD 0,0 to the ALU.
    if (illegal) begin
      op = ALU_ADD;
      a  = '0;
      b  = '0;
    end
  end

  assign alu_op = op;

endmodule

// File: rtl/alu_dispatch.sv
// Two-stage valid/ready wrapper around the external combinational ALU:
// D holds decoded operands driving the ALU, W holds the writeback beat.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic                  out_we,
  output logic                  out_illegal
);

  logic [3:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  logic [4:0]            dec_rd;
  logic                  dec_illegal;

  logic                  d_valid_q, d_valid_d;
  logic [3:0]            d_op_q, d_op_d;
  logic [DATA_WIDTH-1:0] d_a_q, d_a_d, d_b_q, d_b_d;
  logic [4:0]            d_rd_q, d_rd_d;
  logic                  d_illegal_q, d_illegal_d;

  logic                  w_valid_q, w_valid_d;
  logic [4:0]            w_rd_q, w_rd_d;
  logic [DATA_WIDTH-1:0] w_wdata_q, w_wdata_d;
  logic                  w_we_q, w_we_d;
  logic                  w_illegal_q, w_illegal_d;

  logic w_free, accept, advance;

  rv32i_alu_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .alu_op   (dec_op),
    .a        (dec_a),
    .b        (dec_b),
    .rd       (dec_rd),
    .illegal  (dec_illegal)
  );

  assign w_free   = !w_valid_q || out_ready;
  assign in_ready = !d_valid_q || w_free;
  assign accept   = in_valid && in_ready;
  assign advance  = d_valid_q && w_free;

  assign alu_op = d_valid_q ? d_op_q : ALU_ADD;
  assign alu_a  = d_valid_q ? d_a_q  : '0;
  assign alu_b  = d_valid_q ? d_b_q  : '0;

  always_comb begin
    d_valid_d   = d_valid_q;
    d_op_d      = d_op_q;
    d_a_d       = d_a_q;
    d_b_d       = d_b_q;
    d_rd_d      = d_rd_q;
    d_illegal_d = d_illegal_q;
    if (accept) begin
      d_valid_d   = 1'b1;
      d_op_d      = dec_op;
      d_a_d       = dec_a;
      d_b_d       = dec_b;
      d_rd_d      = dec_rd;
      d_illegal_d = dec_illegal;
    end else if (advance) begin
      d_valid_d   = 1'b0;
    end
  end

  always_comb begin
    w_valid_d   = w_valid_q;
    w_rd_d      = w_rd_q;
    w_wdata_d   = w_wdata_q;
    w_we_d      = w_we_q;
    w_illegal_d = w_illegal_q;
    if (advance) begin
      w_valid_d   = 1'b1;
      w_rd_d      = d_rd_q;
      w_wdata_d   = d_illegal_q ? '0 : alu_result;
      w_we_d      = !d_illegal_q && (d_rd_q != 5'd0);
      w_illegal_d = d_illegal_q;
    end else if (out_ready) begin
      w_valid_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q   <= 1'b0;
      d_op_q      <= ALU_ADD;
      d_a_q       <= '0;
      d_b_q       <= '0;
      d_rd_q      <= '0;
      d_illegal_q <= 1'b0;
      w_valid_q   <= 1'b0;
      w_rd_q      <= '0;
      w_wdata_q   <= '0;
      w_we_q      <= 1'b0;
      w_illegal_q <= 1'b0;
    end else begin
      d_valid_q   <= d_valid_d;
      d_op_q      <= d_op_d;
      d_a_q       <= d_a_d;
      d_b_q       <= d_b_d;
      d_rd_q      <= d_rd_d;
      d_illegal_q <= d_illegal_d;
      w_valid_q   <= w_valid_d;
      w_rd_q      <= w_rd_d;
      w_wdata_q   <= w_wdata_d;
      w_we_q      <= w_we_d;
      w_illegal_q <= w_illegal_d;
    end
  end

  assign out_valid   = w_valid_q;
  assign out_rd      = w_rd_q;
  assign out_wdata   = w_wdata_q;
  assign out_we      = w_we_q;
  assign out_illegal = w_illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed RV32I cases, randomized
// streams against an instruction-level reference model, and mid-stream reset.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;
  logic        out_we, out_illegal;

  always #5 clk = ~clk;

  alu_dispatch #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_wdata   (out_wdata),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  // Combinational ALU the block drives.
  always_comb begin
    case (alu_op_e'(alu_op))
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << alu_b[4:0];
      ALU_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
    logic        ill;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural result of one instruction, straight from the ISA rules.
  function automatic exp_t ref_exec(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    logic        ok;
    logic [31:0] r;
    logic [31:0] imm;
    logic [31:0] upper;
    ok    = 1'b1;
    r     = 32'd0;
    imm   = {{20{instr[31]}}, instr[31:20]};
    upper = {instr[31:12], 12'b0};
    case (instr[6:0])
      7'h33: case ({instr[31:25], instr[14:12]})
        {7'h00, 3'd0}: r = rs1 + rs2;
        {7'h20, 3'd0}: r = rs1 - rs2;
        {7'h00, 3'd1}: r = rs1 << rs2[4:0];
        {7'h00, 3'd2}: r = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: r = (rs1 < rs2) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: r = rs1 ^ rs2;
        {7'h00, 3'd5}: r = rs1 >> rs2[4:0];
        {7'h20, 3'd5}: r = $unsigned($signed(rs1) >>> rs2[4:0]);
        {7'h00, 3'd6}: r = rs1 | rs2;
        {7'h00, 3'd7}: r = rs1 & rs2;
        default:       ok = 1'b0;
      endcase
      7'h13: case (instr[14:12])
        3'd0: r = rs1 + imm;
        3'd2: r = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: r = (rs1 < imm) ? 32'd1 : 32'd0;
        3'd4: r = rs1 ^ imm;
        3'd6: r = rs1 | imm;
        3'd7: r = rs1 & imm;
        3'd1: if (instr[31:25] == 7'h00) r = rs1 << instr[24:20]; else ok = 1'b0;
        default: begin
          if (instr[31:25] == 7'h00)      r = rs1 >> instr[24:20];
          else if (instr[31:25] == 7'h20) r = $unsigned($signed(rs1) >>> instr[24:20]);
          else                            ok = 1'b0;
        end
      endcase
      7'h37:   r = upper;
      7'h17:   r = pc + upper;
      default: ok = 1'b0;
    endcase
    e.rd    = instr[11:7];
    e.ill   = !ok;
    e.wdata = ok ? r : 32'd0;
    e.we    = ok && (instr[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        x[6:0]   = 7'h33;
        x[31:25] = ((x[14:12] == 3'd0 || x[14:12] == 3'd5) && x[0 +: 1] == 1'b0) ? 7'h20 : 7'h00;
      end
      3, 4, 5: begin
        x[6:0] = 7'h13;
        if (x[14:12] == 3'd1) x[31:25] = 7'h00;
        if (x[14:12] == 3'd5) x[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      6:       x[6:0] = 7'h37;
      7:       x[6:0] = 7'h17;
      8:       x[6:0] = 7'h33;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
    return x;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_beat(input string tag, input exp_t e);
    check({tag, "_rd"},      32'(out_rd),      32'(e.rd));
    check({tag, "_wdata"},   out_wdata,        e.wdata);
    check({tag, "_we"},      32'(out_we),      32'(e.we));
    check({tag, "_illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask

  // One beat into an empty pipe with out_ready held high; checks latency,
  // ALU drive from D, and the writeback beat.
  task automatic single_beat(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input alu_op_e exp_op, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input logic [31:0] exp_wdata);
    exp_t e;
    e           = ref_exec(instr, pc, rs1, rs2);
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(exp_op));
    check({tag, "_alu_a"}, alu_a, exp_a);
    check({tag, "_alu_b"}, alu_b, exp_b);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_beat(tag, e);
    check({tag, "_wdata_const"}, out_wdata, exp_wdata);
    @(posedge clk); #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // mode 0: in_valid held, out_ready toggles 1,0,1,0..; mode 1: both random.
  task automatic stream(input string tag, input int n, input int mode);
    int          acc;
    int          cyc;
    logic        stall_prev;
    logic [4:0]  p_rd;
    logic [31:0] p_wdata;
    logic        p_we, p_ill;
    exp_t        e;
    acc        = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    p_rd = '0; p_wdata = '0; p_we = 1'b0; p_ill = 1'b0;
    while ((acc < n || sb.size() != 0) && cyc < 4000) begin
      in_valid    = (acc < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      in_instr    = rand_instr();
      in_pc       = rand_data();
      in_rs1_data = rand_data();
      in_rs2_data = rand_data();
      out_ready   = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(!(sb.size() == 2 && !out_ready)));
      if (sb.size() == 0) check({tag, "_no_dup"}, 32'(out_valid), 32'd0);
      if (stall_prev) begin
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_rd"},    32'(out_rd), 32'(p_rd));
        check({tag, "_hold_wdata"}, out_wdata, p_wdata);
        check({tag, "_hold_we"},    32'({out_we, out_illegal}), 32'({p_we, p_ill}));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check_beat(tag, e);
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_exec(in_instr, in_pc, in_rs1_data, in_rs2_data));
        acc++;
      end
      stall_prev = out_valid && !out_ready;
      p_rd = out_rd; p_wdata = out_wdata; p_we = out_we; p_ill = out_illegal;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_complete"}, 32'(acc == n && sb.size() == 0), 32'd1);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_rd",    32'(out_rd), 32'd0);
    check("rst_wdata",     out_wdata, 32'd0);
    check("rst_we_ill",    32'({out_we, out_illegal}), 32'd0);
    check("rst_alu_op",    32'(alu_op), 32'(ALU_ADD));
    check("rst_alu_ab",    alu_a | alu_b, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    single_beat("add", r_type(7'h00, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7,
                ALU_ADD, 32'd5, 32'd7, 32'd12);
    single_beat("srai", i_type({7'h20, 5'd4}, 3'd5, 5'd5), 32'h0, 32'h8000_0000, 32'h0,
                ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single_beat("srli", i_type({7'h00, 5'd4}, 3'd5, 5'd5), 32'h0, 32'h8000_0000, 32'h0,
                ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    single_beat("auipc", u_type(20'hFFFFF, 5'd1, 7'h17), 32'h0000_2000, 32'h0, 32'h0,
                ALU_ADD, 32'h0000_2000, 32'hFFFF_F000, 32'h0000_1000);
    single_beat("lui", u_type(20'h12345, 5'd9, 7'h37), 32'h0000_4000, 32'h1, 32'h2,
                ALU_ADD, 32'h0, 32'h1234_5000, 32'h1234_5000);
    single_beat("opc7f", 32'h0000_007F, 32'h100, 32'h11, 32'h22,
                ALU_ADD, 32'h0, 32'h0, 32'h0);
    single_beat("op_f7_1", r_type(7'h01, 3'd0, 5'd4), 32'h100, 32'd3, 32'd4,
                ALU_ADD, 32'h0, 32'h0, 32'h0);
    single_beat("addi_x0", i_type(12'd1, 3'd0, 5'd0), 32'h0, 32'd9, 32'd0,
                ALU_ADD, 32'd9, 32'd1, 32'd10);
    single_beat("addi_neg", i_type(12'hFFF, 3'd0, 5'd7), 32'h0, 32'd0, 32'd0,
                ALU_ADD, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    stream("b2b", 8, 0);
    stream("rand", 300, 1);

    // Fill D and W with out_ready low, then reset asynchronously mid-cycle.
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_instr    = r_type(7'h00, 3'd0, 5'd3);
    in_rs1_data = 32'd5;
    in_rs2_data = 32'd7;
    @(posedge clk); #1;
    in_instr = r_type(7'h20, 3'd0, 5'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_in_ready",  32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_wdata",     out_wdata, 32'd12);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    check("mid_rst_out",       out_wdata | 32'(out_rd) | 32'({out_we, out_illegal}), 32'd0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_dropped", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
